// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: elastic inter-stage buffer for the pipelined CPU.
// A DEPTH-entry FIFO with valid/ready handshakes on both sides. Stalls hold
// contents, flush discards every entry, and an empty buffer presents BUBBLE.
// All outputs come straight from flops; nothing on the input side reaches the
// output side within the same cycle.
module pipe_stage_buf #(
    parameter int                DATA_W = 75,
    parameter int                DEPTH  = 2,
    parameter logic [DATA_W-1:0] BUBBLE = {DATA_W{1'b0}},
    parameter int                CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  count
);

    localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Storage is deliberately not reset; only the pointers/count give it meaning.
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              push_s;
    logic              pop_s;

    // Handshake qualification: flush cancels both the push and the pop.
    always_comb begin
        push_s = in_valid  && in_ready_q  && !flush;
        pop_s  = out_valid_q && out_ready && !flush;
    end

    // Next pointers and occupancy; wrap uses an explicit compare so any DEPTH works.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = PTR_ZERO;
            rd_ptr_d = PTR_ZERO;
            count_d  = CNT_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_d = (wr_ptr_q == PTR_LAST) ? PTR_ZERO : (wr_ptr_q + PTR_W'(1));
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = (rd_ptr_q == PTR_LAST) ? PTR_ZERO : (rd_ptr_q + PTR_W'(1));
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Next output view: status flags and the head entry after this edge.
    // When the new head is the slot being written right now, take in_data
    // directly since the array write lands on the same edge.
    always_comb begin
        in_ready_d  = (count_d != CNT_FULL);
        out_valid_d = (count_d != CNT_ZERO);
        out_data_d  = BUBBLE;
        if (count_d == CNT_ZERO) begin
            out_data_d = BUBBLE;
        end else if (push_s && (rd_ptr_d == wr_ptr_q)) begin
            out_data_d = in_data;
        end else begin
            out_data_d = mem_q[rd_ptr_d];
        end
    end

    // Control and output registers, cleared asynchronously by rstn.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q    <= PTR_ZERO;
            rd_ptr_q    <= PTR_ZERO;
            count_q     <= CNT_ZERO;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= BUBBLE;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    // Entry storage write on an accepted push.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign count     = count_q;

endmodule
